hls_run_sequencer: RTL and testbench

Synthesizable run controller for a Bambu-generated accelerator using the `start_port`/`done_port` protocol. It resets the accelerator, issues a one-cycle start pulse, and measures latency from start to done. It also enforces a per-run cycle watchdog and repeats the run a programmable number of times. Per-run results and campaign statistics (min/max/total cycles, timeout count) are streamed to on-chip debug logic or a host bridge, replacing the fixed single-run simulation flow with a reusable hardware block.

---
 rtl/hls_run_sequencer_if.sv | 37 +++
 rtl/hls_run_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_hls_run_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_run_sequencer_if.sv
// Signal bundle between the run sequencer and the accelerator/host side.
// The master modport is the sequencer; the slave modport is the environment around it.
interface hls_run_sequencer_if #(
    parameter int RUN_W = 8,
    parameter int CYC_W = 32
);
    logic                   cfg_start;
    logic [RUN_W-1:0]       cfg_num_runs;
    logic [CYC_W-1:0]       cfg_timeout;
    logic                   cfg_stop_on_fail;
    logic                   abort;
    logic                   acc_reset;
    logic                   acc_start_port;
    logic                   acc_done_port;
    logic                   busy;
    logic                   res_valid;
    logic [RUN_W-1:0]       res_run_idx;
    logic [CYC_W-1:0]       res_cycles;
    logic [1:0]             res_status;
    logic                   campaign_done;
    logic [CYC_W-1:0]       stat_min;
    logic [CYC_W-1:0]       stat_max;
    logic [CYC_W+RUN_W-1:0] stat_total;
    logic [RUN_W-1:0]       stat_timeouts;

    modport master (
        input  cfg_start, cfg_num_runs, cfg_timeout, cfg_stop_on_fail, abort, acc_done_port,
        output acc_reset, acc_start_port, busy, res_valid, res_run_idx, res_cycles, res_status,
               campaign_done, stat_min, stat_max, stat_total, stat_timeouts
    );

    modport slave (
        output cfg_start, cfg_num_runs, cfg_timeout, cfg_stop_on_fail, abort, acc_done_port,
        input  acc_reset, acc_start_port, busy, res_valid, res_run_idx, res_cycles, res_status,
               campaign_done, stat_min, stat_max, stat_total, stat_timeouts
    );
endinterface

// File: rtl/hls_run_sequencer.sv
// Campaign controller for a start_port/done_port accelerator: reset, start, time each run,
// enforce a watchdog, repeat, and publish per-run results plus campaign statistics.
module hls_run_sequencer #(
    parameter int RUN_W      = 8,
    parameter int CYC_W      = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    hls_run_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_START,
        S_WAIT,
        S_REPORT,
        S_FINISH
    } state_t;

    localparam int              TOT_W   = CYC_W + RUN_W;
    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [1:0]      ST_OK      = 2'b00;
    localparam logic [1:0]      ST_TIMEOUT = 2'b01;
    localparam logic [1:0]      ST_ABORT   = 2'b10;

    state_t             state_q, state_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   idx_q, idx_d;
    logic [RUN_W-1:0]   num_runs_q, num_runs_d;
    logic [CYC_W-1:0]   timeout_q, timeout_d;
    logic               stop_q, stop_d;
    logic               abort_q, abort_d;
    logic [RUN_W-1:0]   res_idx_q, res_idx_d;
    logic [CYC_W-1:0]   res_cycles_q, res_cycles_d;
    logic [1:0]         res_status_q, res_status_d;
    logic [CYC_W-1:0]   stat_min_q, stat_min_d;
    logic [CYC_W-1:0]   stat_max_q, stat_max_d;
    logic [TOT_W-1:0]   stat_total_q, stat_total_d;
    logic [RUN_W-1:0]   stat_to_q, stat_to_d;

    logic               abort_seen;
    logic [CYC_W-1:0]   cnt_inc;
    logic               last_run;

    // An abort arriving in the current cycle counts as latched, so abort+done resolves as aborted.
    assign abort_seen = abort_q | bus.abort;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);
    assign last_run   = (idx_q == num_runs_q - RUN_W'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            num_runs_q   <= '0;
            timeout_q    <= '0;
            stop_q       <= 1'b0;
            abort_q      <= 1'b0;
            res_idx_q    <= '0;
            res_cycles_q <= '0;
            res_status_q <= '0;
            stat_min_q   <= '1;
            stat_max_q   <= '0;
            stat_total_q <= '0;
            stat_to_q    <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            num_runs_q   <= num_runs_d;
            timeout_q    <= timeout_d;
            stop_q       <= stop_d;
            abort_q      <= abort_d;
            res_idx_q    <= res_idx_d;
            res_cycles_q <= res_cycles_d;
            res_status_q <= res_status_d;
            stat_min_q   <= stat_min_d;
            stat_max_q   <= stat_max_d;
            stat_total_q <= stat_total_d;
            stat_to_q    <= stat_to_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        num_runs_d   = num_runs_q;
        timeout_d    = timeout_q;
        stop_d       = stop_q;
        abort_d      = abort_q | (bus.abort && (state_q != S_IDLE));
        res_idx_d    = res_idx_q;
        res_cycles_d = res_cycles_q;
        res_status_d = res_status_q;
        stat_min_d   = stat_min_q;
        stat_max_d   = stat_max_q;
        stat_total_d = stat_total_q;
        stat_to_d    = stat_to_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    num_runs_d   = bus.cfg_num_runs;
                    timeout_d    = bus.cfg_timeout;
                    stop_d       = bus.cfg_stop_on_fail;
                    stat_min_d   = '1;
                    stat_max_d   = '0;
                    stat_total_d = '0;
                    stat_to_d    = '0;
                    idx_d        = '0;
                    rst_cnt_d    = '0;
                    state_d      = (bus.cfg_num_runs == '0) ? S_FINISH : S_RST;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RC_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = abort_seen ? S_FINISH : S_START;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Result and statistics are registered on entry so they are visible during REPORT.
                res_idx_d = idx_q;
                if (abort_seen) begin
                    res_status_d = ST_ABORT;
                    res_cycles_d = cnt_inc;
                    state_d      = S_REPORT;
                end else if (bus.acc_done_port) begin
                    res_status_d = ST_OK;
                    res_cycles_d = cnt_inc;
                    stat_total_d = stat_total_q + TOT_W'(cnt_inc);
                    if (cnt_inc < stat_min_q) stat_min_d = cnt_inc;
                    if (cnt_inc > stat_max_q) stat_max_d = cnt_inc;
                    state_d      = S_REPORT;
                end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
                    res_status_d = ST_TIMEOUT;
                    res_cycles_d = timeout_q;
                    stat_to_d    = stat_to_q + RUN_W'(1);
                    state_d      = S_REPORT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_REPORT: begin
                if ((res_status_q == ST_ABORT) || last_run ||
                    ((res_status_q == ST_TIMEOUT) && stop_q)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d     = idx_q + RUN_W'(1);
                    rst_cnt_d = '0;
                    // A timed-out accelerator is re-reset; good runs restart immediately.
                    state_d   = (res_status_q == ST_TIMEOUT) ? S_RST : S_START;
                end
            end
            S_FINISH: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.acc_reset      = reset && (state_q != S_RST);
    assign bus.acc_start_port = (state_q == S_START);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.res_valid      = (state_q == S_REPORT);
    assign bus.campaign_done  = (state_q == S_FINISH);
    assign bus.res_run_idx    = res_idx_q;
    assign bus.res_cycles     = res_cycles_q;
    assign bus.res_status     = res_status_q;
    assign bus.stat_min       = stat_min_q;
    assign bus.stat_max       = stat_max_q;
    assign bus.stat_total     = stat_total_q;
    assign bus.stat_timeouts  = stat_to_q;
endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench: campaigns push expected reports/stats, an accelerator model answers starts,
// and a monitor compares every report and campaign end against the queued expectations.
module tb_hls_run_sequencer;
    localparam int RUN_W      = 8;
    localparam int CYC_W      = 32;
    localparam int RST_CYCLES = 2;
    localparam int INF        = 1 << 30;

    typedef struct { int d; int a; } plan_t;               // done / abort delay after start, 0 = never
    typedef struct { int idx; longint cyc; int st; } rep_t;
    typedef struct { longint mn; longint mx; longint tot; int to; int starts; } camp_t;

    logic clock;
    logic reset;

    hls_run_sequencer_if #(.RUN_W(RUN_W), .CYC_W(CYC_W)) bus ();

    hls_run_sequencer #(.RUN_W(RUN_W), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    plan_t pl_q[$];
    plan_t plan_q[$];
    rep_t  rep_q[$];
    camp_t camp_q[$];
    bit    startexp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input int d, input int a);
        plan_t p;
        p.d = d;
        p.a = a;
        pl_q.push_back(p);
    endtask

    // Earliest event wins; within one cycle abort beats done beats timeout.
    function automatic void outcome(input plan_t p, input int t, output int st, output int cy);
        int ea, ed, et, k;
        ea = (p.a != 0) ? p.a : INF;
        ed = (p.d != 0) ? p.d : INF;
        et = (t != 0) ? t : INF;
        k = ea;
        if (ed < k) k = ed;
        if (et < k) k = et;
        cy = k;
        if (ea == k) st = 2;
        else if (ed == k) st = 0;
        else st = 1;
    endfunction

    task automatic flush_all();
        plan_q.delete();
        rep_q.delete();
        camp_q.delete();
        startexp_q.delete();
    endtask

    task automatic check_reset_values();
        chk("rst_acc_reset", bus.acc_reset, 0);
        chk("rst_start", bus.acc_start_port, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_idx", bus.res_run_idx, 0);
        chk("rst_res_cycles", bus.res_cycles, 0);
        chk("rst_res_status", bus.res_status, 0);
        chk("rst_campaign_done", bus.campaign_done, 0);
        chk("rst_stat_min", bus.stat_min, 64'hFFFF_FFFF);
        chk("rst_stat_max", bus.stat_max, 0);
        chk("rst_stat_total", bus.stat_total, 0);
        chk("rst_stat_timeouts", bus.stat_timeouts, 0);
    endtask

    task automatic kick(input int n, input int t, input bit stop);
        @(posedge clock); #1;
        bus.cfg_num_runs     = RUN_W'(n);
        bus.cfg_timeout      = CYC_W'(t);
        bus.cfg_stop_on_fail = stop;
        bus.cfg_start        = 1'b1;
        @(posedge clock); #1;
        bus.cfg_start        = 1'b0;
        bus.cfg_num_runs     = RUN_W'($urandom);
        bus.cfg_timeout      = CYC_W'($urandom_range(1, 5));
        bus.cfg_stop_on_fail = ~stop;
    endtask

    task automatic run_campaign(input int n, input int t, input bit stop);
        camp_t c;
        rep_t  r;
        plan_t p;
        int    st, cy;
        bit    prev_to, seen;
        c.mn = 64'hFFFF_FFFF; c.mx = 0; c.tot = 0; c.to = 0; c.starts = 0;
        prev_to = 1'b1;
        for (int i = 0; i < n; i++) begin
            p = pl_q[i];
            plan_q.push_back(p);
            startexp_q.push_back(prev_to);
            c.starts++;
            outcome(p, t, st, cy);
            r.idx = i; r.cyc = cy; r.st = st;
            rep_q.push_back(r);
            if (st == 0) begin
                if (cy < c.mn) c.mn = cy;
                if (cy > c.mx) c.mx = cy;
                c.tot += cy;
            end else if (st == 1) begin
                c.to++;
            end
            if (st == 2 || (st == 1 && stop)) break;
            prev_to = (st == 1);
        end
        camp_q.push_back(c);
        $display("campaign runs=%0d timeout=%0d stop=%0d expected_reports=%0d", n, t, stop, rep_q.size());
        kick(n, t, stop);
        if (n == 0) begin
            @(negedge clock);
            chk("zero_runs_done", bus.campaign_done, 1);
            chk("zero_runs_no_start", bus.acc_start_port, 0);
            return;
        end
        for (int k = 1; k <= RST_CYCLES + 1; k++) begin
            if (k > 1) @(posedge clock);
            @(negedge clock);
            chk("first_start_acc_reset", bus.acc_reset, (k > RST_CYCLES));
            chk("first_start_pulse", bus.acc_start_port, (k == RST_CYCLES + 1));
        end
        seen = 1'b0;
        for (int w = 0; w < 5000 && !seen; w++) begin
            @(posedge clock); #1;
            bus.cfg_start = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            if (bus.campaign_done) seen = 1'b1;
        end
        bus.cfg_start = 1'b0;
        if (!seen) begin
            chk("campaign_end_seen", 0, 1);
            flush_all();
        end
    endtask

    initial begin : monitor
        int    low_run;
        int    starts;
        rep_t  r;
        camp_t c;
        bit    e;
        low_run = 0;
        starts  = 0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                low_run = 0;
                starts  = 0;
            end else begin
                if (bus.acc_start_port) begin
                    starts++;
                    if (startexp_q.size() == 0) begin
                        chk("unexpected_start", 0, 1);
                    end else begin
                        e = startexp_q.pop_front();
                        chk("rst_before_start", low_run, e ? RST_CYCLES : 0);
                    end
                end
                if (!bus.acc_reset) low_run++;
                else low_run = 0;
                if (bus.res_valid) begin
                    $display("report idx=%0d cycles=%0d status=%0d", bus.res_run_idx, bus.res_cycles, bus.res_status);
                    if (rep_q.size() == 0) begin
                        chk("unexpected_report", 0, 1);
                    end else begin
                        r = rep_q.pop_front();
                        chk("report_idx", bus.res_run_idx, r.idx);
                        chk("report_cycles", bus.res_cycles, r.cyc);
                        chk("report_status", bus.res_status, r.st);
                    end
                end
                if (bus.campaign_done) begin
                    $display("campaign_done min=%0d max=%0d total=%0d timeouts=%0d starts=%0d",
                             bus.stat_min, bus.stat_max, bus.stat_total, bus.stat_timeouts, starts);
                    if (camp_q.size() == 0) begin
                        chk("unexpected_campaign_done", 0, 1);
                    end else begin
                        c = camp_q.pop_front();
                        chk("stat_min", bus.stat_min, c.mn);
                        chk("stat_max", bus.stat_max, c.mx);
                        chk("stat_total", bus.stat_total, c.tot);
                        chk("stat_timeouts", bus.stat_timeouts, c.to);
                        chk("start_count", starts, c.starts);
                        chk("reports_outstanding", rep_q.size(), 0);
                    end
                    starts = 0;
                end
            end
        end
    end

    initial begin : responder
        plan_t p;
        int    k;
        bus.acc_done_port = 1'b0;
        bus.abort         = 1'b0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && bus.acc_start_port === 1'b1) begin
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else begin p.d = 0; p.a = 0; end
                k = 0;
                forever begin
                    @(posedge clock); #1;
                    k++;
                    bus.acc_done_port = (k == p.d);
                    bus.abort         = (k == p.a);
                    @(negedge clock);
                    if (bus.res_valid || reset !== 1'b1 || k > 20000) break;
                end
                bus.acc_done_port = 1'b0;
                bus.abort         = 1'b0;
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clock);
        $display("FAIL global_watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation did not complete");
    end

    initial begin : main
        int  n, t;
        bit  stop, seen;
        rep_t r;
        reset                = 1'b0;
        bus.cfg_start        = 1'b0;
        bus.cfg_num_runs     = '0;
        bus.cfg_timeout      = '0;
        bus.cfg_stop_on_fail = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values();
        @(posedge clock); #1;
        reset = 1'b1;

        pl_q.delete(); add(10, 0); add(20, 0); add(5, 0);
        run_campaign(3, 0, 0);
        pl_q.delete(); add(0, 0); add(0, 0);
        run_campaign(2, 8, 0);
        pl_q.delete(); add(3, 0); add(0, 0); add(4, 0); add(4, 0);
        run_campaign(4, 8, 1);
        pl_q.delete(); add(0, 4); add(5, 0); add(5, 0); add(5, 0); add(5, 0);
        run_campaign(5, 0, 0);
        pl_q.delete(); add(6, 0);
        run_campaign(1, 6, 0);
        pl_q.delete(); add(7, 7);
        run_campaign(1, 0, 0);
        pl_q.delete();
        run_campaign(0, 5, 0);

        for (int c = 0; c < 14; c++) begin
            n    = $urandom_range(1, 6);
            t    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 30);
            stop = 1'($urandom_range(0, 1));
            pl_q.delete();
            for (int i = 0; i < n; i++) begin
                if (t == 0) add($urandom_range(1, 40), ($urandom_range(0, 9) == 0) ? $urandom_range(1, 40) : 0);
                else add(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, t),
                         ($urandom_range(0, 9) == 0) ? $urandom_range(1, 40) : 0);
            end
            run_campaign(n, t, stop);
        end

        // Reset while run 2 is waiting, then a fresh campaign must start from idx 0.
        pl_q.delete(); add(5, 0); add(5, 0); add(50, 0);
        for (int i = 0; i < 3; i++) begin
            plan_q.push_back(pl_q[i]);
            startexp_q.push_back(i == 0);
        end
        for (int i = 0; i < 2; i++) begin
            r.idx = i; r.cyc = 5; r.st = 0;
            rep_q.push_back(r);
        end
        kick(4, 0, 0);
        seen = 1'b0;
        for (int w = 0; w < 2000 && !seen; w++) begin
            @(negedge clock);
            if (rep_q.size() == 0 && startexp_q.size() == 0) seen = 1'b1;
        end
        chk("midreset_reached_run2", seen, 1);
        repeat (10) @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("midreset_acc_reset_immediate", bus.acc_reset, 0);
        @(posedge clock);
        @(negedge clock);
        check_reset_values();
        flush_all();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        pl_q.delete(); add(7, 0); add(9, 0);
        run_campaign(2, 0, 0);

        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
